// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmitter and the future receiver
//   state_t    - frame FSM states
//   PAR_*      - parity mode encodings
//   frame_len  - baud periods per frame for a given configuration
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + (parity != PAR_NONE ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/edge_tick.sv
// edge_tick: one-clk pulse on each rising edge of sig
//   clk  - system clock
//   rst  - synchronous active-high reset
//   sig  - slow square wave sampled in the clk domain
//   tick - high for the single clk cycle where sig has just risen
module edge_tick (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic tick
);

    logic sig_q;

    // Resetting to 1 keeps a sig that is already high at reset release from looking like an edge.
    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b1;
        else     sig_q <= sig;
    end

    assign tick = sig & ~sig_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer with a one-entry holding register
//   clk      - system clock
//   rst      - synchronous active-high reset
//   bclk     - baud square wave; each rising edge is a bit period boundary
//   in_data  - byte to transmit
//   in_valid - in_data is valid
//   in_ready - holding register empty; accept on in_valid && in_ready
//   tx       - serial line, idle high
//   busy     - a frame is in progress
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bclk,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);

    import uart_pkg::*;

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       HAS_PAR   = PARITY != PAR_NONE;
    localparam logic       ODD       = PARITY == PAR_ODD;

    state_t               state;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] shift;
    logic                 hold_full;
    logic                 par;
    logic [2:0]           cnt;
    logic                 tick;
    logic                 stop_end;
    logic                 load;

    edge_tick u_tick (
        .clk  (clk),
        .rst  (rst),
        .sig  (bclk),
        .tick (tick)
    );

    assign in_ready = !hold_full;
    assign stop_end = state == STOP && cnt == LAST_STOP;
    // A held byte starts a frame from IDLE or straight after the last stop bit, giving no idle gap.
    assign load     = tick && hold_full && (state == IDLE || stop_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            shift     <= '0;
            hold_full <= 1'b0;
            par       <= 1'b0;
            cnt       <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end
            if (load) begin
                shift     <= hold;
                hold_full <= 1'b0;
                state     <= START;
                cnt       <= '0;
                tx        <= 1'b0;
                busy      <= 1'b1;
            end else if (tick) begin
                case (state)
                    START: begin
                        state <= DATA;
                        cnt   <= '0;
                        par   <= 1'b0;
                        tx    <= shift[0];
                    end
                    DATA: begin
                        shift <= shift >> 1;
                        par   <= par ^ shift[0];
                        if (cnt == LAST_DATA) begin
                            cnt   <= '0;
                            state <= HAS_PAR ? uart_pkg::PARITY : STOP;
                            // par has not yet absorbed the last bit, so fold it in here.
                            tx    <= HAS_PAR ? par ^ shift[0] ^ ODD : 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                            tx  <= shift[1];
                        end
                    end
                    uart_pkg::PARITY: begin
                        state <= STOP;
                        cnt   <= '0;
                        tx    <= 1'b1;
                    end
                    STOP: begin
                        if (stop_end) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx across 8N1, 8E1, 8O1 and 8N2 configurations
module tb_uart_tx;

    typedef bit bq_t[$];

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       bclk     = 1'b0;
    logic       bclk_run = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic [3:0] vld      = 4'h0;
    logic [3:0] tx_v, busy_v, rdy_v;
    logic [1:0] sel = 2'd0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         par_c[4]  = '{0, 1, 2, 0};
    int         stop_c[4] = '{1, 1, 1, 2};
    logic       txl[$], busyl[$], rdyl[$];

    wire txs   = tx_v[sel];
    wire busys = busy_v[sel];
    wire rdys  = rdy_v[sel];

    always #5 clk = ~clk;
    always #80 if (bclk_run) bclk = ~bclk;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (.clk(clk), .rst(rst), .bclk(bclk), .in_data(in_data), .in_valid(vld[0]), .in_ready(rdy_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (.clk(clk), .rst(rst), .bclk(bclk), .in_data(in_data), .in_valid(vld[1]), .in_ready(rdy_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (.clk(clk), .rst(rst), .bclk(bclk), .in_data(in_data), .in_valid(vld[2]), .in_ready(rdy_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (.clk(clk), .rst(rst), .bclk(bclk), .in_data(in_data), .in_valid(vld[3]), .in_ready(rdy_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

    // Reference frame: start 0, data LSB first, optional parity, stop ones.
    function automatic bq_t frame(input logic [7:0] b, input int par, input int stops);
        bq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(b[i]);
        if (par != 0) q.push_back(($countones(b) % 2 == 1) ^ (par == 2));
        for (int i = 0; i < stops; i++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld = 4'h0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic offer(input logic [7:0] b, input bit keep);
        int w = 0;
        in_data  = b;
        vld[sel] = 1'b1;
        while (rdys !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w >= 2000) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", rdys, w);
        end
        @(posedge clk);
        #1;
        if (!keep) vld[sel] = 1'b0;
    endtask

    // Records tx/busy/in_ready on n negedges, index 0 being the first with tx low.
    task automatic capture(input int n);
        int w = 0;
        @(negedge clk);
        while (txs !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w >= 3000) begin
            n_fail++;
            $display("FAIL start_timeout: tx=%0b after %0d cycles, required start bit 0", txs, w);
        end
        txl.delete();
        busyl.delete();
        rdyl.delete();
        for (int j = 0; j < n; j++) begin
            txl.push_back(txs);
            busyl.push_back(busys);
            rdyl.push_back(rdys);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tx_v[i] !== 1'b1) begin n_fail++; $display("FAIL reset_tx[%0d]: got %0b want 1", i, tx_v[i]); end
            n_checks++;
            if (busy_v[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %0b want 0", i, busy_v[i]); end
            n_checks++;
            if (rdy_v[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %0b want 1", i, rdy_v[i]); end
        end
    endtask

    task automatic test_8n1();
        bq_t e = frame(8'h55, 0, 1);
        int  nb = 0;
        sel = 2'd0;
        fork
            offer(8'h55, 1'b0);
            capture(169);
        join
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (txl[8 + 16 * k] !== e[k]) begin n_fail++; $display("FAIL 8n1_bit%0d: got %0b want %0b", k, txl[8 + 16 * k], e[k]); end
        end
        foreach (busyl[j]) nb += int'(busyl[j] === 1'b1);
        n_checks++;
        if (nb != 160) begin n_fail++; $display("FAIL 8n1_busy_len: got %0d cycles want 160", nb); end
        n_checks++;
        if (txl[168] !== 1'b1 || busyl[168] !== 1'b0) begin n_fail++; $display("FAIL 8n1_idle_after: tx=%0b busy=%0b want tx=1 busy=0", txl[168], busyl[168]); end
    endtask

    task automatic test_parity();
        for (int s = 1; s <= 2; s++) begin
            bq_t e = frame(8'hA5, s, 1);
            int  nb = 0;
            sel = 2'(s);
            fork
                offer(8'hA5, 1'b0);
                capture(11 * 16 + 9);
            join
            n_checks++;
            if (txl[8 + 16 * 9] !== (s == 2)) begin n_fail++; $display("FAIL parity_bit mode%0d: got %0b want %0b", s, txl[8 + 16 * 9], s == 2); end
            for (int k = 0; k < 11; k++) begin
                n_checks++;
                if (txl[8 + 16 * k] !== e[k]) begin n_fail++; $display("FAIL parity%0d_bit%0d: got %0b want %0b", s, k, txl[8 + 16 * k], e[k]); end
            end
            foreach (busyl[j]) nb += int'(busyl[j] === 1'b1);
            n_checks++;
            if (nb != 176) begin n_fail++; $display("FAIL parity%0d_len: got %0d cycles want 176", s, nb); end
        end
    endtask

    task automatic test_back_to_back();
        bq_t e  = frame(8'h01, 0, 1);
        bq_t e2 = frame(8'h80, 0, 1);
        int  nb = 0;
        int  nr = 0;
        foreach (e2[i]) e.push_back(e2[i]);
        sel = 2'd0;
        fork
            begin
                offer(8'h01, 1'b1);
                offer(8'h80, 1'b0);
            end
            capture(20 * 16 + 9);
        join
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (txl[8 + 16 * k] !== e[k]) begin n_fail++; $display("FAIL b2b_bit%0d: got %0b want %0b", k, txl[8 + 16 * k], e[k]); end
        end
        for (int j = 0; j < 320; j++) nb += int'(busyl[j] === 1'b1);
        n_checks++;
        if (nb != 320) begin n_fail++; $display("FAIL b2b_busy_gap: busy high %0d of 320 cycles", nb); end
        for (int j = 1; j < 160; j++) nr += int'(rdyl[j] === 1'b0);
        n_checks++;
        if (nr != 159) begin n_fail++; $display("FAIL b2b_ready_low: in_ready low %0d of 159 cycles", nr); end
        n_checks++;
        if (rdyl[160] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_rise: got %0b want 1 after frame-2 load", rdyl[160]); end
        n_checks++;
        if (busyl[328] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: busy=%0b want 0", busyl[328]); end
    endtask

    task automatic test_bclk_reset();
        int nl = 0;
        sel = 2'd0;
        bclk_run = 1'b0;
        @(negedge clk);
        bclk = 1'b1;
        do_reset();
        offer(8'h3C, 1'b0);
        repeat (40) begin
            @(negedge clk);
            nl += int'(txs !== 1'b1) + int'(busys !== 1'b0);
        end
        n_checks++;
        if (nl != 0) begin n_fail++; $display("FAIL bclk_release_tick: %0d cycles with tx/busy disturbed, want 0", nl); end
        bclk = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (txs !== 1'b1 || rdys !== 1'b0) begin n_fail++; $display("FAIL bclk_pre_edge: tx=%0b ready=%0b want tx=1 ready=0", txs, rdys); end
        bclk = 1'b1;
        @(negedge clk);
        n_checks++;
        if (txs !== 1'b0 || busys !== 1'b1) begin n_fail++; $display("FAIL bclk_first_edge: tx=%0b busy=%0b want tx=0 busy=1", txs, busys); end
        bclk_run = 1'b1;
        repeat (12 * 16 + 8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] a = 8'($urandom) & 8'hF7;
        logic [7:0] b = 8'($urandom);
        int         nl = 0;
        sel = 2'd0;
        fork
            begin
                offer(a, 1'b1);
                offer(b, 1'b0);
            end
            capture(72);
        join
        n_checks++;
        if (rdyl[71] !== 1'b0) begin n_fail++; $display("FAIL midreset_held: in_ready=%0b want 0 before reset", rdyl[71]); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (txs !== 1'b1 || rdys !== 1'b1 || busys !== 1'b0) begin n_fail++; $display("FAIL midreset_abort: tx=%0b ready=%0b busy=%0b want 1 1 0", txs, rdys, busys); end
        rst = 1'b0;
        repeat (480) begin
            @(negedge clk);
            nl += int'(txs !== 1'b1) + int'(busys !== 1'b0);
        end
        n_checks++;
        if (nl != 0) begin n_fail++; $display("FAIL midreset_discard: %0d cycles active after reset, want 0", nl); end
    endtask

    task automatic test_two_stop();
        logic [7:0] nxt = 8'($urandom);
        int         nl = 0;
        int         nh = 0;
        sel = 2'd3;
        fork
            begin
                offer(8'hFF, 1'b1);
                offer(nxt, 1'b0);
            end
            capture(12 * 16 + 9);
        join
        for (int j = 0; j < 16; j++) nl += int'(txl[j] === 1'b0);
        for (int j = 16; j < 176; j++) nh += int'(txl[j] === 1'b1);
        n_checks++;
        if (nl != 16) begin n_fail++; $display("FAIL 2stop_start_len: low %0d cycles want 16", nl); end
        n_checks++;
        if (nh != 160) begin n_fail++; $display("FAIL 2stop_high_len: high %0d cycles want 160", nh); end
        n_checks++;
        if (txl[176] !== 1'b0 || busyl[176] !== 1'b1) begin n_fail++; $display("FAIL 2stop_next_start: tx=%0b busy=%0b want 0 1 at the 11th tick", txl[176], busyl[176]); end
        repeat (12 * 16) @(negedge clk);
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < 3; r++) begin
                logic [7:0] b = 8'($urandom);
                bq_t        e = frame(b, par_c[s], stop_c[s]);
                int         n = e.size();
                sel = 2'(s);
                fork
                    offer(b, 1'b0);
                    capture(16 * n + 9);
                join
                for (int k = 0; k < n; k++) begin
                    n_checks++;
                    if (txl[8 + 16 * k] !== e[k]) begin n_fail++; $display("FAIL rand cfg%0d byte %02h bit%0d: got %0b want %0b", s, b, k, txl[8 + 16 * k], e[k]); end
                end
                n_checks++;
                if (txl[16 * n + 8] !== 1'b1 || busyl[16 * n + 8] !== 1'b0) begin n_fail++; $display("FAIL rand cfg%0d end: tx=%0b busy=%0b want 1 0", s, txl[16 * n + 8], busyl[16 * n + 8]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_bclk_reset();
        test_reset_mid();
        test_two_stop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
